// File: rtl/conv2d_job_sequencer.sv
// Sequences one conv2D_int16 job: filter load, feature stream, then result drain and idle gap.
// Define CONV_SEQ_TIMEOUT_EN to add the drain watchdog (err_code 11).
module conv2d_job_sequencer #(
    parameter int unsigned FILT_WORDS  = 9,
    parameter int unsigned IDLE_GAP    = 2,
    parameter int unsigned TIMEOUT_CYC = 4096
) (
    input  logic        AXIS_ACLK,
    input  logic        AXIS_ARESET,
    input  logic        start,
    input  logic [31:0] cfg_len,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [1:0]  err_code,
    output logic [31:0] res_count,
    input  logic [15:0] F_AXIS_TDATA,
    input  logic        F_AXIS_TVALID,
    input  logic        F_AXIS_TLAST,
    output logic        F_AXIS_TREADY,
    input  logic [15:0] D_AXIS_TDATA,
    input  logic        D_AXIS_TVALID,
    input  logic        D_AXIS_TLAST,
    output logic        D_AXIS_TREADY,
    output logic [15:0] C_AXIS_TDATA,
    output logic [1:0]  C_AXIS_TKEEP,
    output logic        C_AXIS_TVALID,
    output logic        C_AXIS_TLAST,
    input  logic        C_AXIS_TREADY,
    input  logic        R_AXIS_TVALID,
    input  logic        R_AXIS_TREADY,
    input  logic        R_AXIS_TLAST
);

    localparam logic [31:0] FiltLast = 32'(FILT_WORDS - 1);
    localparam logic [31:0] GapLast  = 32'(IDLE_GAP - 1);
    localparam logic [1:0]  ErrLen   = 2'b01;
    localparam logic [1:0]  ErrLast  = 2'b10;

    typedef enum logic [2:0] {StIdle, StLoadF, StStream, StDrain, StGap} state_e;

    state_e      state_q, state_d;
    logic [31:0] beat_q, beat_d;
    logic [31:0] lat_len_q, lat_len_d;
    logic [31:0] exp_res_q, exp_res_d;
    logic [31:0] res_count_q, res_count_d;
    logic        err_q, err_d;
    logic [1:0]  err_code_q, err_code_d;
    logic        len_ok;
    logic        c_beat;
    logic        r_beat;
    logic        wdog_hit;

    assign len_ok = (cfg_len % 32'd3 == 32'd0) && (cfg_len >= 32'd9);
    assign r_beat = R_AXIS_TVALID && R_AXIS_TREADY;

`ifdef CONV_SEQ_TIMEOUT_EN
    localparam logic [31:0] WdogLast   = 32'(TIMEOUT_CYC - 1);
    localparam logic [1:0]  ErrTimeout = 2'b11;

    logic [31:0] wdog_q, wdog_d;

    // Counts consecutive DRAIN cycles without a result beat.
    always_comb begin
        wdog_d = '0;
        if (state_q == StDrain && !r_beat) begin
            wdog_d = wdog_q + 32'd1;
        end
    end

    assign wdog_hit = (state_q == StDrain) && !r_beat && (wdog_q == WdogLast);

    always_ff @(posedge AXIS_ACLK) begin
        if (AXIS_ARESET) begin
            wdog_q <= '0;
        end else begin
            wdog_q <= wdog_d;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYC;
    assign wdog_hit       = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        beat_d        = beat_q;
        lat_len_d     = lat_len_q;
        exp_res_d     = exp_res_q;
        res_count_d   = res_count_q;
        err_d         = err_q;
        err_code_d    = err_code_q;
        C_AXIS_TDATA  = '0;
        C_AXIS_TVALID = 1'b0;
        C_AXIS_TLAST  = 1'b0;
        F_AXIS_TREADY = 1'b0;
        D_AXIS_TREADY = 1'b0;
        done          = 1'b0;
        c_beat        = 1'b0;

        if ((state_q == StStream || state_q == StDrain) && r_beat) begin
            res_count_d = res_count_q + 32'd1;
        end

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (len_ok) begin
                        state_d     = StLoadF;
                        beat_d      = '0;
                        lat_len_d   = cfg_len;
                        exp_res_d   = cfg_len / 32'd3 - 32'd2;
                        res_count_d = '0;
                        err_d       = 1'b0;
                        err_code_d  = 2'b00;
                    end else begin
                        err_d      = 1'b1;
                        err_code_d = ErrLen;
                    end
                end
            end
            StLoadF: begin
                C_AXIS_TDATA  = F_AXIS_TDATA;
                C_AXIS_TVALID = F_AXIS_TVALID;
                F_AXIS_TREADY = C_AXIS_TREADY;
                C_AXIS_TLAST  = (beat_q == FiltLast);
                c_beat        = F_AXIS_TVALID && C_AXIS_TREADY;
                if (c_beat) begin
                    if (F_AXIS_TLAST != C_AXIS_TLAST) begin
                        err_d      = 1'b1;
                        err_code_d = ErrLast;
                    end
                    if (C_AXIS_TLAST) begin
                        state_d = StStream;
                        beat_d  = '0;
                    end else begin
                        beat_d = beat_q + 32'd1;
                    end
                end
            end
            StStream: begin
                C_AXIS_TDATA  = D_AXIS_TDATA;
                C_AXIS_TVALID = D_AXIS_TVALID;
                D_AXIS_TREADY = C_AXIS_TREADY;
                C_AXIS_TLAST  = (beat_q == lat_len_q - 32'd1);
                c_beat        = D_AXIS_TVALID && C_AXIS_TREADY;
                if (c_beat) begin
                    if (D_AXIS_TLAST != C_AXIS_TLAST) begin
                        err_d      = 1'b1;
                        err_code_d = ErrLast;
                    end
                    if (C_AXIS_TLAST) begin
                        state_d = StDrain;
                        beat_d  = '0;
                    end else begin
                        beat_d = beat_q + 32'd1;
                    end
                end
            end
            StDrain: begin
                if (r_beat && R_AXIS_TLAST) begin
                    done    = 1'b1;
                    state_d = StGap;
                    beat_d  = '0;
                    // res_count_d already includes this final beat.
                    if (res_count_d != exp_res_q) begin
                        err_d      = 1'b1;
                        err_code_d = ErrLast;
                    end
                end
`ifdef CONV_SEQ_TIMEOUT_EN
                else if (wdog_hit) begin
                    err_d      = 1'b1;
                    err_code_d = ErrTimeout;
                    state_d    = StGap;
                    beat_d     = '0;
                end
`endif
            end
            StGap: begin
                if (beat_q == GapLast) begin
                    state_d = StIdle;
                    beat_d  = '0;
                end else begin
                    beat_d = beat_q + 32'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge AXIS_ACLK) begin
        if (AXIS_ARESET) begin
            state_q     <= StIdle;
            beat_q      <= '0;
            lat_len_q   <= '0;
            exp_res_q   <= '0;
            res_count_q <= '0;
            err_q       <= 1'b0;
            err_code_q  <= 2'b00;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            lat_len_q   <= lat_len_d;
            exp_res_q   <= exp_res_d;
            res_count_q <= res_count_d;
            err_q       <= err_d;
            err_code_q  <= err_code_d;
        end
    end

    assign busy         = (state_q != StIdle);
    assign err          = err_q;
    assign err_code     = err_code_q;
    assign res_count    = res_count_q;
    assign C_AXIS_TKEEP = 2'b11;

endmodule

// File: tb/tb_conv2d_job_sequencer.sv
// Self-checking bench for conv2d_job_sequencer: randomized jobs against a queue-based job model.
`timescale 1ns/1ps
module tb_conv2d_job_sequencer;

    localparam int FW  = 9;
    localparam int GAP = 2;
`ifdef CONV_SEQ_TIMEOUT_EN
    localparam int TO_CYC = 16;
`else
    localparam int TO_CYC = 4096;
`endif
    localparam int PhIdle  = 0;
    localparam int PhWork  = 1;
    localparam int PhDrain = 2;
    localparam int PhGap   = 3;

    logic        clk;
    logic        AXIS_ARESET;
    logic        start;
    logic [31:0] cfg_len;
    logic        busy, done, err;
    logic [1:0]  err_code;
    logic [31:0] res_count;
    logic [15:0] F_AXIS_TDATA, D_AXIS_TDATA, C_AXIS_TDATA;
    logic        F_AXIS_TVALID, F_AXIS_TLAST, F_AXIS_TREADY;
    logic        D_AXIS_TVALID, D_AXIS_TLAST, D_AXIS_TREADY;
    logic [1:0]  C_AXIS_TKEEP;
    logic        C_AXIS_TVALID, C_AXIS_TLAST, C_AXIS_TREADY;
    logic        R_AXIS_TVALID, R_AXIS_TREADY, R_AXIS_TLAST;

    conv2d_job_sequencer #(
        .FILT_WORDS  (FW),
        .IDLE_GAP    (GAP),
        .TIMEOUT_CYC (TO_CYC)
    ) dut (
        .AXIS_ACLK     (clk),
        .AXIS_ARESET   (AXIS_ARESET),
        .start         (start),
        .cfg_len       (cfg_len),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .err_code      (err_code),
        .res_count     (res_count),
        .F_AXIS_TDATA  (F_AXIS_TDATA),
        .F_AXIS_TVALID (F_AXIS_TVALID),
        .F_AXIS_TLAST  (F_AXIS_TLAST),
        .F_AXIS_TREADY (F_AXIS_TREADY),
        .D_AXIS_TDATA  (D_AXIS_TDATA),
        .D_AXIS_TVALID (D_AXIS_TVALID),
        .D_AXIS_TLAST  (D_AXIS_TLAST),
        .D_AXIS_TREADY (D_AXIS_TREADY),
        .C_AXIS_TDATA  (C_AXIS_TDATA),
        .C_AXIS_TKEEP  (C_AXIS_TKEEP),
        .C_AXIS_TVALID (C_AXIS_TVALID),
        .C_AXIS_TLAST  (C_AXIS_TLAST),
        .C_AXIS_TREADY (C_AXIS_TREADY),
        .R_AXIS_TVALID (R_AXIS_TVALID),
        .R_AXIS_TREADY (R_AXIS_TREADY),
        .R_AXIS_TLAST  (R_AXIS_TLAST)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Source and result-side drivers
    logic [15:0] f_data [FW];
    logic [15:0] d_data [$];
    int  f_idx = FW, d_idx = 0, d_len = 0, f_tl_at = FW - 1;
    bit  f_rand = 0, d_rand = 0, r_en = 0, r_rand = 0;
    int  c_mode = 0, r_n = 0, r_sent = 0;
    bit  f_fire, d_fire, r_fire_s;

    // Job model: expected core-side beats plus job-level status
    typedef struct {
        logic [15:0] data;
        logic        last;
        logic        filt;
    } beat_t;
    beat_t       exp_q [$];
    int          m_phase = PhIdle;
    int          m_cons = 0, m_gap = 0;
    logic [31:0] m_len = 0, m_res = 0, m_wd = 0;
    logic        m_err = 0;
    logic [1:0]  m_code = 0;
    int          done_cnt = 0, cbeat_cnt = 0;
    bit          mon_on = 0;

    task automatic cycle();
        @(negedge clk);
        f_fire   = F_AXIS_TVALID && F_AXIS_TREADY;
        d_fire   = D_AXIS_TVALID && D_AXIS_TREADY;
        r_fire_s = R_AXIS_TVALID && R_AXIS_TREADY;
        @(posedge clk);
        #1;
        if (f_fire) f_idx++;
        if (f_idx < FW) begin
            if (!F_AXIS_TVALID || f_fire) F_AXIS_TVALID = f_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            F_AXIS_TDATA = f_data[f_idx];
            F_AXIS_TLAST = (f_idx == f_tl_at);
        end else begin
            F_AXIS_TVALID = 1'b0;
            F_AXIS_TLAST  = 1'b0;
        end
        if (d_fire) d_idx++;
        if (d_idx < d_len) begin
            if (!D_AXIS_TVALID || d_fire) D_AXIS_TVALID = d_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            D_AXIS_TDATA = d_data[d_idx];
            D_AXIS_TLAST = (d_idx == d_len - 1);
        end else begin
            D_AXIS_TVALID = 1'b0;
            D_AXIS_TLAST  = 1'b0;
        end
        case (c_mode)
            0:       C_AXIS_TREADY = 1'b1;
            1:       C_AXIS_TREADY = ~C_AXIS_TREADY;
            default: C_AXIS_TREADY = 1'($urandom_range(0, 1));
        endcase
        if (r_fire_s) r_sent++;
        if (r_en && r_sent < r_n) begin
            if (!R_AXIS_TVALID || r_fire_s) R_AXIS_TVALID = r_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            R_AXIS_TLAST = (r_sent == r_n - 1);
        end else begin
            R_AXIS_TVALID = 1'b0;
            R_AXIS_TLAST  = 1'b0;
        end
        R_AXIS_TREADY = r_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    endtask

    task automatic setup_sources(input int len, input bit fr, input bit dr, input int ftl);
        for (int i = 0; i < FW; i++) f_data[i] = 16'($urandom);
        d_data.delete();
        for (int i = 0; i < len; i++) d_data.push_back(16'($urandom));
        f_idx = 0; d_idx = 0; d_len = len; f_tl_at = ftl;
        f_rand = fr; d_rand = dr;
        r_en = 0; r_sent = 0;
    endtask

    task automatic stop_sources();
        f_idx = FW; d_idx = d_len; r_en = 0;
        F_AXIS_TVALID = 1'b0; D_AXIS_TVALID = 1'b0; R_AXIS_TVALID = 1'b0;
    endtask

    task automatic run_job(input int len, input bit fr, input bit dr, input int cm,
                           input int ftl, input int rn, input bit rr);
        int n;
        setup_sources(len, fr, dr, ftl);
        c_mode  = cm;
        cfg_len = 32'(len);
        start   = 1'b1;
        cycle();
        start = 1'b0;
        n = 0;
        while (m_phase == PhWork && n < 4000) begin cycle(); n++; end
        r_n = rn; r_sent = 0; r_rand = rr; r_en = 1;
        n = 0;
        while (m_phase != PhIdle && n < 4000) begin cycle(); n++; end
        chk("job_completion_bound", 32'(n >= 4000), 0);
        r_en = 0;
        cycle();
    endtask

    // Compare process: checks every cycle's outputs, then advances the model across the edge.
    initial begin
        beat_t e;
        logic  cf, rf, exp_done, src_last, popped;
        forever begin
            @(negedge clk);
            if (mon_on) begin
                cf       = C_AXIS_TVALID && C_AXIS_TREADY;
                rf       = R_AXIS_TVALID && R_AXIS_TREADY;
                exp_done = (m_phase == PhDrain) && rf && R_AXIS_TLAST;
                popped   = 1'b0;
                src_last = 1'b0;
                chk("busy", 32'(busy), 32'(m_phase != PhIdle));
                chk("done", 32'(done), 32'(exp_done));
                chk("err", 32'(err), 32'(m_err));
                chk("err_code", 32'(err_code), 32'(m_code));
                chk("res_count", res_count, m_res);
                chk("c_tkeep", 32'(C_AXIS_TKEEP), 3);
                if (done) done_cnt++;
                if (m_phase == PhWork && exp_q.size() > 0) begin
                    if (exp_q[0].filt) begin
                        chk("f_tready", 32'(F_AXIS_TREADY), 32'(C_AXIS_TREADY));
                        chk("d_tready_in_load", 32'(D_AXIS_TREADY), 0);
                        chk("c_tvalid_load", 32'(C_AXIS_TVALID), 32'(F_AXIS_TVALID));
                    end else begin
                        chk("d_tready", 32'(D_AXIS_TREADY), 32'(C_AXIS_TREADY));
                        chk("f_tready_in_stream", 32'(F_AXIS_TREADY), 0);
                        chk("c_tvalid_stream", 32'(C_AXIS_TVALID), 32'(D_AXIS_TVALID));
                    end
                    if (cf) begin
                        e = exp_q.pop_front();
                        popped = 1'b1;
                        cbeat_cnt++;
                        chk("c_tdata", 32'(C_AXIS_TDATA), 32'(e.data));
                        chk("c_tlast", 32'(C_AXIS_TLAST), 32'(e.last));
                        src_last = e.filt ? F_AXIS_TLAST : D_AXIS_TLAST;
                    end
                end else begin
                    chk("c_tvalid_inactive", 32'(C_AXIS_TVALID), 0);
                    chk("f_tready_inactive", 32'(F_AXIS_TREADY), 0);
                    chk("d_tready_inactive", 32'(D_AXIS_TREADY), 0);
                end

                if (AXIS_ARESET) begin
                    exp_q.delete();
                    m_phase = PhIdle; m_cons = 0; m_gap = 0;
                    m_len = 0; m_res = 0; m_wd = 0; m_err = 0; m_code = 0;
                end else begin
                    case (m_phase)
                        PhIdle: begin
                            if (start) begin
                                if (cfg_len % 3 == 0 && cfg_len >= 9) begin
                                    for (int i = 0; i < FW; i++)
                                        exp_q.push_back('{data: f_data[i], last: (i == FW - 1), filt: 1'b1});
                                    for (int i = 0; i < int'(cfg_len); i++)
                                        exp_q.push_back('{data: d_data[i], last: (i == int'(cfg_len) - 1),
                                                          filt: 1'b0});
                                    m_len = cfg_len; m_res = 0; m_err = 0; m_code = 0;
                                    m_cons = 0; m_phase = PhWork;
                                end else begin
                                    m_err = 1; m_code = 2'b01;
                                end
                            end
                        end
                        PhWork: begin
                            if (rf && m_cons >= FW) m_res++;
                            if (popped) begin
                                if (src_last != e.last) begin m_err = 1; m_code = 2'b10; end
                                m_cons++;
                                if (m_cons == FW + int'(m_len)) begin m_phase = PhDrain; m_wd = 0; end
                            end
                        end
                        PhDrain: begin
                            if (rf) begin
                                m_res++;
                                m_wd = 0;
                                if (R_AXIS_TLAST) begin
                                    if (m_res != m_len / 3 - 2) begin m_err = 1; m_code = 2'b10; end
                                    m_phase = PhGap; m_gap = GAP;
                                end
                            end else begin
`ifdef CONV_SEQ_TIMEOUT_EN
                                m_wd++;
                                if (m_wd == TO_CYC) begin
                                    m_err = 1; m_code = 2'b11; m_phase = PhGap; m_gap = GAP;
                                end
`endif
                            end
                        end
                        default: begin
                            m_gap--;
                            if (m_gap == 0) m_phase = PhIdle;
                        end
                    endcase
                end
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL global_time_limit: got running expected finished");
        $fatal(1, "time limit");
    end

    initial begin
        int d0, b0, n, len, rn;
        AXIS_ARESET = 1'b1; start = 1'b0; cfg_len = '0;
        F_AXIS_TDATA = '0; F_AXIS_TVALID = 1'b0; F_AXIS_TLAST = 1'b0;
        D_AXIS_TDATA = '0; D_AXIS_TVALID = 1'b0; D_AXIS_TLAST = 1'b0;
        C_AXIS_TREADY = 1'b0;
        R_AXIS_TVALID = 1'b0; R_AXIS_TREADY = 1'b0; R_AXIS_TLAST = 1'b0;
        cycle();
        cycle();
        mon_on = 1;
        cycle();
        AXIS_ARESET = 1'b0;
        cycle();
        chk("reset_busy", 32'(busy), 0);
        chk("reset_err", 32'(err), 0);
        chk("reset_err_code", 32'(err_code), 0);
        chk("reset_res_count", res_count, 0);
        chk("reset_c_tvalid", 32'(C_AXIS_TVALID), 0);

        // Nominal job: 9 + 27 core beats, 7 result beats
        d0 = done_cnt; b0 = cbeat_cnt;
        run_job(27, 0, 0, 0, FW - 1, 7, 0);
        chk("t1_core_beats", 32'(cbeat_cnt - b0), 36);
        chk("t1_done_pulses", 32'(done_cnt - d0), 1);
        chk("t1_res_count", res_count, 7);
        chk("t1_err", 32'(err), 0);

        // Same job with C_TREADY toggling each cycle
        d0 = done_cnt; b0 = cbeat_cnt;
        run_job(27, 0, 0, 1, FW - 1, 7, 0);
        chk("t2_core_beats", 32'(cbeat_cnt - b0), 36);
        chk("t2_done_pulses", 32'(done_cnt - d0), 1);
        chk("t2_err", 32'(err), 0);

        // Bad lengths
        cfg_len = 32'd10; start = 1'b1; cycle(); start = 1'b0; cycle();
        chk("t3_len10_err_code", 32'(err_code), 1);
        chk("t3_len10_busy", 32'(busy), 0);
        cfg_len = 32'd6; start = 1'b1; cycle(); start = 1'b0; cycle();
        chk("t3_len6_err", 32'(err), 1);
        chk("t3_len6_err_code", 32'(err_code), 1);
        chk("t3_len6_busy", 32'(busy), 0);

        // Early filter TLAST on beat 8
        d0 = done_cnt;
        run_job(27, 0, 0, 0, 7, 7, 0);
        chk("t4_err_code", 32'(err_code), 2);
        chk("t4_done_pulses", 32'(done_cnt - d0), 1);

        // start mid-stream ignored, then reset mid-stream
        setup_sources(18, 0, 0, FW - 1);
        c_mode = 0; cfg_len = 32'd18; start = 1'b1; cycle(); start = 1'b0;
        n = 0;
        while (m_cons < FW + 4 && n < 500) begin cycle(); n++; end
        cfg_len = 32'd9; start = 1'b1; cycle(); start = 1'b0;
        chk("t5_busy_after_restart", 32'(busy), 1);
        AXIS_ARESET = 1'b1; cycle(); AXIS_ARESET = 1'b0;
        stop_sources();
        cycle();
        chk("t5_reset_busy", 32'(busy), 0);
        chk("t5_reset_c_tvalid", 32'(C_AXIS_TVALID), 0);
        chk("t5_reset_res_count", res_count, 0);
        chk("t5_reset_err_code", 32'(err_code), 0);

        // Randomized jobs, some with a wrong result-beat count
        for (int j = 0; j < 8; j++) begin
            len = 3 * int'($urandom_range(3, 12));
            rn  = len / 3 - 2 + (($urandom_range(0, 3) == 0) ? 1 : 0);
            run_job(len, 1, 1, 2, FW - 1, rn, 1);
            chk("rand_err_flag", 32'(err), 32'(rn != len / 3 - 2));
        end

`ifdef CONV_SEQ_TIMEOUT_EN
        d0 = done_cnt;
        run_job(18, 0, 0, 0, FW - 1, 0, 0);
        chk("t6_err_code", 32'(err_code), 3);
        chk("t6_no_done", 32'(done_cnt - d0), 0);
        chk("t6_busy", 32'(busy), 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
